// File: rtl/fetch_unit_prefetch.sv
// rtl/fetch_unit_prefetch.sv - sequential instruction prefetch with redirect flush and condition-gated IR load
// Credit-based fetch into a small FIFO; a redirect flushes queued words and drops in-flight beats.
module fetch_unit_prefetch #(
    parameter int unsigned          ADDR_W     = 32,
    parameter int unsigned          DATA_W     = 32,
    parameter int unsigned          FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0]    RESET_PC   = '0,
    parameter int unsigned          PC_STEP    = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              write_ir,
    input  logic [3:0]        NZCV,
    output logic [DATA_W-1:0] IR,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              W_IR_valid,
    output logic              fetch_stall
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d, out_q, out_d, drop_q, drop_d;
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q   [FIFO_DEPTH];

    logic              empty, credit, drop_now, push, pop, cond_ok;
    logic [DATA_W-1:0] head_data;
    logic [ADDR_W-1:0] head_pc;
    logic [3:0]        cond_c;

    assign empty     = (count_q == '0);
    assign credit    = ({1'b0, count_q} + {1'b0, out_q}) < (CW+1)'(FIFO_DEPTH);
    assign imem_req  = ~rst & ~redirect & credit;
    assign imem_addr = fetch_pc_q;
    assign head_data = fifo_data_q[rd_ptr_q];
    assign head_pc   = fifo_pc_q[rd_ptr_q];
    assign cond_c    = head_data[31:28];
    // Beats owed to a flushed stream are swallowed before anything reaches the FIFO.
    assign drop_now  = imem_rvalid & (drop_q != '0);
    assign push      = imem_rvalid & ~drop_now & ~redirect;
    assign pop       = write_ir & ~redirect & ~empty;
    assign W_IR_valid  = pop & cond_ok;
    assign fetch_stall = write_ir & empty;
    assign IR        = ir_q;
    assign ir_pc     = ir_pc_q;

    always_comb begin
        cond_ok = 1'b1;
        case (cond_c)
            4'h0:    cond_ok = NZCV[2];
            4'h1:    cond_ok = ~NZCV[2];
            4'h2:    cond_ok = NZCV[1];
            4'h3:    cond_ok = ~NZCV[1];
            4'h4:    cond_ok = NZCV[3];
            4'h5:    cond_ok = ~NZCV[3];
            4'h6:    cond_ok = NZCV[0];
            4'h7:    cond_ok = ~NZCV[0];
            4'h8:    cond_ok = NZCV[1] & ~NZCV[2];
            4'h9:    cond_ok = ~NZCV[1] | NZCV[2];
            4'hA:    cond_ok = (NZCV[3] == NZCV[0]);
            4'hB:    cond_ok = (NZCV[3] != NZCV[0]);
            4'hC:    cond_ok = ~NZCV[2] & (NZCV[3] == NZCV[0]);
            4'hD:    cond_ok = NZCV[2] | (NZCV[3] != NZCV[0]);
            default: cond_ok = 1'b1;
        endcase
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        out_d      = out_q;
        drop_d     = drop_q;
        if (redirect) begin
            // Everything still in flight becomes a drop, minus a beat landing right now.
            fetch_pc_d = redirect_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            out_d      = '0;
            drop_d     = drop_q + out_q - CW'(imem_rvalid);
        end else begin
            if (imem_req) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
            end
            out_d   = out_q + CW'(imem_req) - CW'(push);
            drop_d  = drop_q - CW'(drop_now);
            count_d = count_q + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (W_IR_valid) begin
                ir_d    = head_data;
                ir_pc_d = head_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= imem_rdata;
            fifo_pc_q[wr_ptr_q]   <= fetch_pc_q - ADDR_W'(PC_STEP) * ADDR_W'(out_q);
        end
    end
endmodule

// File: tb/tb_fetch_unit_prefetch.sv
// tb/tb_fetch_unit_prefetch.sv - scoreboard bench for fetch_unit_prefetch
// Memory model queues responses at a fixed latency; expected IR words are queued at request time.
module tb_fetch_unit_prefetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        write_ir = 1'b0;
    logic [3:0]  NZCV = 4'h0;
    logic [31:0] IR, ir_pc;
    logic        W_IR_valid, fetch_stall;

    logic        imem_req2, W_IR_valid2, fetch_stall2;
    logic [31:0] imem_addr2, IR2, ir_pc2;
    logic        rv2 = 1'b0;
    logic [31:0] rd2 = '0;

    always #5 clk = ~clk;

    fetch_unit_prefetch dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .write_ir(write_ir), .NZCV(NZCV), .IR(IR),
        .ir_pc(ir_pc), .W_IR_valid(W_IR_valid), .fetch_stall(fetch_stall)
    );

    fetch_unit_prefetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rvalid(rv2), .imem_rdata(rd2), .redirect(redirect),
        .redirect_pc(redirect_pc), .write_ir(write_ir), .NZCV(NZCV), .IR(IR2),
        .ir_pc(ir_pc2), .W_IR_valid(W_IR_valid2), .fetch_stall(fetch_stall2)
    );

    typedef struct { int due; logic [31:0] data; } pend_t;
    typedef struct { logic [31:0] data; logic [31:0] pc; } exp_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          lat = 1;
    int          cyc = 0;
    logic [3:0]  mem_cond = 4'hE;
    pend_t       pend_q[$];
    exp_t        exp_q[$];
    logic        chk_pending = 1'b0;
    exp_t        chk_item;

    function automatic logic [31:0] word_at(input logic [31:0] a, input logic [3:0] c);
        return {c, 28'(a >> 2)};
    endfunction

    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    // Memory model plus scoreboard pop at each consuming cycle.
    initial begin
        exp_t  e;
        logic  p;
        logic [31:0] w;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (rst) begin
                pend_q.delete();
                exp_q.delete();
                imem_rvalid = 1'b0;
            end else begin
                if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = pend_q[0].data;
                    void'(pend_q.pop_front());
                end else begin
                    imem_rvalid = 1'b0;
                    imem_rdata  = 32'hDEAD_BEEF;
                end
                if (imem_req) begin
                    w = word_at(imem_addr, mem_cond);
                    pend_q.push_back('{cyc + lat, w});
                    exp_q.push_back('{w, imem_addr});
                end
            end
            #1;
            if (!rst) begin
                if (redirect) begin
                    exp_q.delete();
                end else if (write_ir && !fetch_stall) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL sb_underflow: pop with no expected word at cycle %0d", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        p = cond_ref(e.data[31:28], NZCV);
                        if (W_IR_valid !== p) begin
                            miscompares++;
                            $display("FAIL sb_wir: got %b expected %b word %h", W_IR_valid, p, e.data);
                        end
                        if (p) begin
                            chk_pending = 1'b1;
                            chk_item    = e;
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (chk_pending) begin
                chk_pending = 1'b0;
                vectors++;
                if (IR !== chk_item.data || ir_pc !== chk_item.pc) begin
                    miscompares++;
                    $display("FAIL sb_ir: got %h@%h expected %h@%h", IR, ir_pc, chk_item.data, chk_item.pc);
                end
            end
        end
    end

    task automatic do_reset(input int l);
        @(negedge clk);
        rst = 1'b1; redirect = 1'b0; write_ir = 1'b0; lat = l;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; write_ir = 1'b1;
        repeat (2) @(negedge clk);
        #4;
        vectors++;
        if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b expected 0", imem_req); end
        @(posedge clk); #1;
        vectors++;
        if (IR !== 32'h0 || ir_pc !== 32'h0) begin miscompares++; $display("FAIL rst_ir: got %h@%h expected 0@0", IR, ir_pc); end
        vectors++;
        if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h expected 0", imem_addr); end
        vectors++;
        if (fetch_stall !== 1'b1 || W_IR_valid !== 1'b0) begin
            miscompares++; $display("FAIL rst_flags: got stall=%b wir=%b expected 1,0", fetch_stall, W_IR_valid);
        end
    endtask

    task automatic test_stream;
        mem_cond = 4'hE;
        do_reset(1);
        write_ir = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #4;
            vectors++;
            if (imem_addr !== 32'(i * 4)) begin miscompares++; $display("FAIL stream_addr: got %h expected %h", imem_addr, 32'(i * 4)); end
        end
        @(posedge clk); #1;
        vectors++;
        if (IR !== 32'hE000_0000 || ir_pc !== 32'h0) begin miscompares++; $display("FAIL stream_first: got %h@%h expected e0000000@0", IR, ir_pc); end
        @(posedge clk); #1;
        vectors++;
        if (IR !== 32'hE000_0001 || ir_pc !== 32'h4) begin miscompares++; $display("FAIL stream_second: got %h@%h expected e0000001@4", IR, ir_pc); end
        repeat (10) @(negedge clk);
        write_ir = 1'b0;
    endtask

    task automatic test_cond;
        do_reset(1);
        mem_cond = 4'h0;
        repeat (2) @(negedge clk);
        mem_cond = 4'h9;
        repeat (6) @(negedge clk);
        NZCV = 4'b0000; write_ir = 1'b1;
        #4;
        vectors++;
        if (W_IR_valid !== 1'b0) begin miscompares++; $display("FAIL cond_eq_skip: got %b expected 0", W_IR_valid); end
        @(posedge clk); #1;
        vectors++;
        if (IR !== 32'h0) begin miscompares++; $display("FAIL cond_eq_hold: got %h expected 0", IR); end
        @(negedge clk);
        NZCV = 4'b0100;
        #4;
        vectors++;
        if (W_IR_valid !== 1'b1) begin miscompares++; $display("FAIL cond_eq_take: got %b expected 1", W_IR_valid); end
        @(posedge clk); #1;
        vectors++;
        if (IR !== 32'h1 || ir_pc !== 32'h4) begin miscompares++; $display("FAIL cond_eq_ir: got %h@%h expected 1@4", IR, ir_pc); end
        @(negedge clk);
        NZCV = 4'b0010;
        #4;
        vectors++;
        if (W_IR_valid !== 1'b0) begin miscompares++; $display("FAIL cond_ls_skip: got %b expected 0", W_IR_valid); end
        @(posedge clk); #1;
        vectors++;
        if (IR !== 32'h1) begin miscompares++; $display("FAIL cond_ls_hold: got %h expected 1", IR); end
        @(negedge clk);
        write_ir = 1'b0; NZCV = 4'h0; mem_cond = 4'hE;
    endtask

    task automatic test_credit;
        int n;
        do_reset(1);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            #4;
            if (imem_req) n++;
        end
        vectors++;
        if (n !== 4) begin miscompares++; $display("FAIL credit_fill: got %0d reqs expected 4", n); end
        vectors++;
        if (imem_req !== 1'b0) begin miscompares++; $display("FAIL credit_full: got %b expected 0", imem_req); end
        @(negedge clk); write_ir = 1'b1;
        @(negedge clk); write_ir = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #4;
            if (imem_req) n++;
        end
        vectors++;
        if (n !== 1) begin miscompares++; $display("FAIL credit_refill: got %0d reqs expected 1", n); end
    endtask

    task automatic test_redirect;
        bit seen;
        do_reset(3);
        @(negedge clk);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h100;
        #4;
        vectors++;
        if (imem_req !== 1'b0) begin miscompares++; $display("FAIL redir_req: got %b expected 0", imem_req); end
        @(negedge clk);
        redirect = 1'b0; write_ir = 1'b1;
        #4;
        vectors++;
        if (imem_addr !== 32'h100) begin miscompares++; $display("FAIL redir_addr: got %h expected 100", imem_addr); end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #4;
            if (W_IR_valid) seen = 1;
        end
        @(posedge clk); #1;
        vectors++;
        if (!seen || IR !== word_at(32'h100, 4'hE) || ir_pc !== 32'h100) begin
            miscompares++; $display("FAIL redir_ir: got %h@%h seen=%0d expected %h@100", IR, ir_pc, seen, word_at(32'h100, 4'hE));
        end
        @(negedge clk); write_ir = 1'b0;
        repeat (8) @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h200; write_ir = 1'b1;
        #4;
        vectors++;
        if (W_IR_valid !== 1'b0 || imem_req !== 1'b0) begin
            miscompares++; $display("FAIL redir_wir: got wir=%b req=%b expected 0,0", W_IR_valid, imem_req);
        end
        @(posedge clk); #1;
        vectors++;
        if (IR !== word_at(32'h100, 4'hE)) begin miscompares++; $display("FAIL redir_hold: got %h expected %h", IR, word_at(32'h100, 4'hE)); end
        @(negedge clk);
        redirect = 1'b0;
        #4;
        vectors++;
        if (imem_addr !== 32'h200) begin miscompares++; $display("FAIL redir2_addr: got %h expected 200", imem_addr); end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk); #4;
            if (W_IR_valid) seen = 1;
        end
        @(posedge clk); #1;
        vectors++;
        if (!seen || IR !== word_at(32'h200, 4'hE) || ir_pc !== 32'h200) begin
            miscompares++; $display("FAIL redir2_ir: got %h@%h seen=%0d expected %h@200", IR, ir_pc, seen, word_at(32'h200, 4'hE));
        end
        @(negedge clk); write_ir = 1'b0;
    endtask

    task automatic test_reset_mid;
        do_reset(1);
        write_ir = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (IR !== 32'h0 || ir_pc !== 32'h0) begin miscompares++; $display("FAIL mid_ir: got %h@%h expected 0@0", IR, ir_pc); end
        vectors++;
        if (imem_addr !== 32'h0 || imem_req !== 1'b0) begin miscompares++; $display("FAIL mid_addr: got %h req=%b expected 0,0", imem_addr, imem_req); end
        vectors++;
        if (fetch_stall !== 1'b1) begin miscompares++; $display("FAIL mid_empty: got stall=%b expected 1", fetch_stall); end
        @(negedge clk);
        rst = 1'b0;
        #4;
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL mid_restart: got %h req=%b expected 0,1", imem_addr, imem_req); end
        @(negedge clk); write_ir = 1'b0;
    endtask

    task automatic test_wrap;
        logic [31:0] exp_a [3];
        exp_a[0] = 32'hFFFF_FFFC; exp_a[1] = 32'h0; exp_a[2] = 32'h4;
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #4;
            vectors++;
            if (imem_addr2 !== exp_a[i] || imem_req2 !== 1'b1) begin
                miscompares++; $display("FAIL wrap_addr: got %h req=%b expected %h,1", imem_addr2, imem_req2, exp_a[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_cond();
        test_credit();
        test_redirect();
        test_reset_mid();
        test_wrap();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
